// File: rtl/wb_stage.sv
// Registered write-back stage: selects and extends one result source, buffers it in a
// 2-entry skid queue, drives the register-file write port and serves forwarding lookups.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | no entries held, out_valid low
// ST_ONE   | head entry valid, one free slot
// ST_FULL  | head and tail valid, in_ready low
module wb_stage #(
   parameter int DW       = 16,
   parameter int NSRC     = 6,
   parameter int SELW     = (NSRC > 1) ? $clog2(NSRC) : 1,
   parameter int AW       = 3,
   parameter int ZERO_REG = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SELW-1:0]      wb_sel,
   input  logic [NSRC*DW-1:0]   src_data,
   input  logic [1:0]           ext_mode,
   input  logic                 wb_en,
   input  logic [AW-1:0]        rd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_waddr,
   output logic [DW-1:0]        rf_wdata,
   input  logic [AW-1:0]        fwd_addr,
   output logic                 fwd_hit,
   output logic [DW-1:0]        fwd_data,
   output logic                 sel_err
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          we_q   [2];
   logic          we_d   [2];
   logic [AW-1:0] rd_q   [2];
   logic [AW-1:0] rd_d   [2];
   logic [DW-1:0] data_q [2];
   logic [DW-1:0] data_d [2];
   logic          sel_err_q, sel_err_d;

   logic          acc;
   logic          pop;
   logic          sel_oor;
   logic [DW-1:0] sel_data;
   logic [DW-1:0] ext_data;
   logic          new_we;
   logic          wr_head;
   logic          hit_head;
   logic          hit_tail;

   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Unmatched select values fall back to source 0 and are flagged as out of range.
   always_comb begin
      sel_oor  = 1'b1;
      sel_data = src_data[DW-1:0];
      for (int k = 0; k < NSRC; k++) begin
         if (wb_sel == SELW'(k)) begin
            sel_oor  = 1'b0;
            sel_data = src_data[k*DW +: DW];
         end
      end
   end

   always_comb begin
      ext_data = sel_data;
      case (ext_mode)
         2'b01:   ext_data = {{(DW-8){1'b0}}, sel_data[7:0]};
         2'b10:   ext_data = {{(DW-8){sel_data[7]}}, sel_data[7:0]};
         default: ext_data = sel_data;
      endcase
   end

   assign new_we = wb_en && !((ZERO_REG != 0) && (rd == '0));

   // A simultaneous accept and pop from ONE replaces the head directly.
   assign wr_head = (state_q == ST_EMPTY) || pop;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (acc) state_d = ST_ONE;
         ST_ONE: begin
            if (acc && !pop)      state_d = ST_FULL;
            else if (pop && !acc) state_d = ST_EMPTY;
         end
         ST_FULL:  if (pop) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      we_d   = we_q;
      rd_d   = rd_q;
      data_d = data_q;
      if (pop && !acc) begin
         we_d[0]   = we_q[1];
         rd_d[0]   = rd_q[1];
         data_d[0] = data_q[1];
      end
      if (acc) begin
         if (wr_head) begin
            we_d[0]   = new_we;
            rd_d[0]   = rd;
            data_d[0] = ext_data;
         end else begin
            we_d[1]   = new_we;
            rd_d[1]   = rd;
            data_d[1] = ext_data;
         end
      end
   end

   assign sel_err_d = sel_err_q || (acc && sel_oor);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         we_q      <= '{default: 1'b0};
         rd_q      <= '{default: '0};
         data_q    <= '{default: '0};
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign rf_we    = pop && we_q[0];
   assign rf_waddr = rd_q[0];
   assign rf_wdata = data_q[0];
   assign sel_err  = sel_err_q;

   // The tail is the younger entry, so it wins when both match.
   assign hit_head = out_valid && we_q[0] && (rd_q[0] == fwd_addr);
   assign hit_tail = (state_q == ST_FULL) && we_q[1] && (rd_q[1] == fwd_addr);
   assign fwd_hit  = hit_head || hit_tail;
   assign fwd_data = hit_tail ? data_q[1] : (hit_head ? data_q[0] : '0);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_stage;

   localparam int DW   = 16;
   localparam int NSRC = 6;
   localparam int SELW = 3;
   localparam int AW   = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [SELW-1:0]   wb_sel;
   logic [NSRC*DW-1:0] src_data;
   logic [1:0]        ext_mode;
   logic              wb_en;
   logic [AW-1:0]     rd;
   logic              out_valid;
   logic              out_ready;
   logic              rf_we;
   logic [AW-1:0]     rf_waddr;
   logic [DW-1:0]     rf_wdata;
   logic [AW-1:0]     fwd_addr;
   logic              fwd_hit;
   logic [DW-1:0]     fwd_data;
   logic              sel_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          we;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   always #5 clk = ~clk;

   wb_stage #(.DW(DW), .NSRC(NSRC), .SELW(SELW), .AW(AW), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .wb_sel(wb_sel), .src_data(src_data), .ext_mode(ext_mode), .wb_en(wb_en),
      .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_addr(fwd_addr),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .sel_err(sel_err)
   );

   task automatic set_src(input int k, input logic [DW-1:0] v);
      src_data[k*DW +: DW] = v;
   endtask

   task automatic push_src0(input logic [DW-1:0] v, input logic [AW-1:0] r, input logic en);
      in_valid = 1'b1; wb_sel = 3'd0; ext_mode = 2'b00; wb_en = en; rd = r;
      set_src(0, v);
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; wb_sel = '0; src_data = '0; ext_mode = '0;
      wb_en = 1'b0; rd = '0; out_ready = 1'b0; fwd_addr = '0;
      #3;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== '0 ||
          rf_wdata !== '0 || fwd_hit !== 1'b0 || fwd_data !== '0 || sel_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got rdy=%b ov=%b we=%b wa=%0d wd=%h hit=%b fd=%h err=%b, want 1 0 0 0 0000 0 0000 0",
                  in_ready, out_valid, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, sel_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1; in_valid = 1'b1; wb_sel = 3'd2; ext_mode = 2'b00;
      set_src(2, 16'h1234); rd = 3'd5; wb_en = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 16'h1234 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_flow: got we=%b wa=%0d wd=%h ov=%b, want 1 5 1234 1", rf_we, rf_waddr, rf_wdata, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || rf_we !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: got ov=%b we=%b, want 0 0", out_valid, rf_we);
      end
   endtask

   task automatic test_extension;
      logic [DW-1:0] src_t [3];
      logic [1:0]    mode_t [3];
      logic [DW-1:0] exp_t [3];
      src_t  = '{16'h00F0, 16'h00F0, 16'hAB70};
      mode_t = '{2'b10, 2'b01, 2'b10};
      exp_t  = '{16'hFFF0, 16'h00F0, 16'h0070};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_src0(src_t[i], 3'd1, 1'b1);
         ext_mode = mode_t[i];
         @(posedge clk); #1;
         in_valid = 1'b0;
         #1;
         checks++;
         if (rf_wdata !== exp_t[i] || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL extension_%0d: got wd=%h we=%b, want %h 1", i, rf_wdata, rf_we, exp_t[i]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      push_src0(16'h1111, 3'd1, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_one: got rdy=%b ov=%b, want 1 1", in_ready, out_valid);
      end
      push_src0(16'h2222, 3'd2, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full_ready: got %b, want 0", in_ready);
      end
      push_src0(16'h3333, 3'd3, 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (in_ready !== 1'b0 || rf_we !== 1'b0 || rf_wdata !== 16'h1111 || rf_waddr !== 3'd1) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%b we=%b wa=%0d wd=%h, want 0 0 1 1111", in_ready, rf_we, rf_waddr, rf_wdata);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 16'h1111) begin
         errors++;
         $display("FAIL bp_write_a: got we=%b wa=%0d wd=%h, want 1 1 1111", rf_we, rf_waddr, rf_wdata);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 16'h2222) begin
         errors++;
         $display("FAIL bp_write_b: got rdy=%b we=%b wa=%0d wd=%h, want 1 1 2 2222", in_ready, rf_we, rf_waddr, rf_wdata);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_third_dropped: got ov=%b, want 0", out_valid);
      end
   endtask

   task automatic test_forwarding;
      out_ready = 1'b0;
      push_src0(16'hAAAA, 3'd3, 1'b1);
      @(posedge clk); #1;
      push_src0(16'hBBBB, 3'd3, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      fwd_addr = 3'd3;
      #1;
      checks++;
      if (fwd_hit !== 1'b1 || fwd_data !== 16'hBBBB) begin
         errors++;
         $display("FAIL fwd_tail_wins: got hit=%b data=%h, want 1 bbbb", fwd_hit, fwd_data);
      end
      fwd_addr = 3'd4;
      #1;
      checks++;
      if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin
         errors++;
         $display("FAIL fwd_miss: got hit=%b data=%h, want 0 0000", fwd_hit, fwd_data);
      end
      idle_cycles(3);
      out_ready = 1'b0;
      push_src0(16'hAAAA, 3'd3, 1'b1);
      @(posedge clk); #1;
      push_src0(16'hCCCC, 3'd6, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      fwd_addr = 3'd6;
      #1;
      checks++;
      if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin
         errors++;
         $display("FAIL fwd_no_we: got hit=%b data=%h, want 0 0000", fwd_hit, fwd_data);
      end
      fwd_addr = 3'd3;
      #1;
      checks++;
      if (fwd_hit !== 1'b1 || fwd_data !== 16'hAAAA) begin
         errors++;
         $display("FAIL fwd_head_only: got hit=%b data=%h, want 1 aaaa", fwd_hit, fwd_data);
      end
      idle_cycles(3);
   endtask

   task automatic test_zero_reg;
      out_ready = 1'b1;
      fwd_addr = 3'd0;
      for (int i = 0; i < 4; i++) begin
         push_src0(16'h0F00 + 16'(i), 3'd0, 1'b1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         #1;
         checks++;
         if (out_valid !== 1'b1 || rf_we !== 1'b0 || fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_%0d: got ov=%b we=%b hit=%b, want 1 0 0", i, out_valid, rf_we, fwd_hit);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_sel_err;
      out_ready = 1'b1;
      for (int k = 0; k < NSRC; k++) set_src(k, 16'h5A5A + 16'(k * 16'h0101));
      wb_sel = 3'd7; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (sel_err !== 1'b0) begin
         errors++;
         $display("FAIL sel_err_no_accept: got %b, want 0", sel_err);
      end
      in_valid = 1'b1; wb_en = 1'b1; rd = 3'd2; ext_mode = 2'b00;
      @(posedge clk); #1;
      in_valid = 1'b0; wb_sel = 3'd1;
      #1;
      checks++;
      if (rf_wdata !== 16'h5A5A || sel_err !== 1'b1) begin
         errors++;
         $display("FAIL sel_err_data: got wd=%h err=%b, want 5a5a 1", rf_wdata, sel_err);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sel_err !== 1'b1) begin
         errors++;
         $display("FAIL sel_err_sticky: got %b, want 1", sel_err);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      push_src0(16'h4444, 3'd4, 1'b1);
      @(posedge clk); #1;
      push_src0(16'h5555, 3'd5, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      fwd_addr = 3'd5;
      #1;
      checks++;
      if (in_ready !== 1'b0 || fwd_hit !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_full: got rdy=%b hit=%b, want 0 1", in_ready, fwd_hit);
      end
      #1;
      rst_n = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || rf_we !== 1'b0 || in_ready !== 1'b1 || fwd_hit !== 1'b0 || sel_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: got ov=%b we=%b rdy=%b hit=%b err=%b, want 0 0 1 0 0",
                  out_valid, rf_we, in_ready, fwd_hit, sel_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: got ov=%b we=%b, want 0 0", out_valid, rf_we);
         end
      end
   endtask

   function automatic logic [DW-1:0] model_data(input int sel, input int mode);
      int d;
      int lo;
      d  = (sel < NSRC) ? int'(src_data[sel*DW +: DW]) : int'(src_data[DW-1:0]);
      lo = d % 256;
      if (mode == 1)      d = lo;
      else if (mode == 2) d = (lo >= 128) ? lo + 65280 : lo;
      return DW'(d);
   endfunction

   task automatic test_random;
      ent_t q[$];
      ent_t e;
      logic exp_err;
      logic exp_hit;
      logic [DW-1:0] exp_fd;
      logic acc_m, pop_m;
      exp_err = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         wb_sel    = SELW'($urandom_range(0, 7));
         ext_mode  = 2'($urandom_range(0, 3));
         wb_en     = 1'($urandom_range(0, 1));
         rd        = AW'($urandom_range(0, 7));
         fwd_addr  = AW'($urandom_range(0, 7));
         for (int k = 0; k < NSRC; k++) set_src(k, DW'($urandom));
         #1;
         exp_hit = 1'b0;
         exp_fd  = '0;
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (!exp_hit && q[i].we && q[i].rd == fwd_addr) begin
               exp_hit = 1'b1;
               exp_fd  = q[i].data;
            end
         end
         checks++;
         if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0) ||
             rf_we !== (q.size() != 0 && out_ready && q[0].we) ||
             fwd_hit !== exp_hit || fwd_data !== exp_fd || sel_err !== exp_err) begin
            errors++;
            $display("FAIL rand_ctl cyc %0d: got rdy=%b ov=%b we=%b hit=%b fd=%h err=%b, want n=%0d hit=%b fd=%h err=%b",
                     cyc, in_ready, out_valid, rf_we, fwd_hit, fwd_data, sel_err, q.size(), exp_hit, exp_fd, exp_err);
         end
         if (q.size() != 0) begin
            checks++;
            if (rf_waddr !== q[0].rd || rf_wdata !== q[0].data) begin
               errors++;
               $display("FAIL rand_head cyc %0d: got wa=%0d wd=%h, want %0d %h", cyc, rf_waddr, rf_wdata, q[0].rd, q[0].data);
            end
         end
         acc_m = in_valid && (q.size() < 2);
         pop_m = out_ready && (q.size() > 0);
         if (pop_m) void'(q.pop_front());
         if (acc_m) begin
            e.we   = wb_en && (rd != 0);
            e.rd   = rd;
            e.data = model_data(int'(wb_sel), int'(ext_mode));
            q.push_back(e);
            if (int'(wb_sel) >= NSRC) exp_err = 1'b1;
         end
         @(posedge clk); #1;
      end
      idle_cycles(3);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extension();
      test_backpressure();
      test_forwarding();
      test_zero_reg();
      test_sel_err();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
